key_search: RTL and testbench

//  Brute-force key search controller that sits beside arc4: drives arc4 key/en,

---
 rtl/key_search.sv | 186 ++++++++++++++++++
 tb/tb_key_search.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_search.sv
// key_search: brute-force key search controller that sits beside arc4.
// For each candidate key it starts arc4, waits for the decryption to finish,
// then scans the plaintext memory. The plaintext is valid when byte 0 (length
// L) is non-zero and bytes 1..L all lie in [CHAR_MIN, CHAR_MAX].
// Keys are tried as KEY_START, KEY_START+KEY_STEP, ... up to KEY_END inclusive,
// and the first key that passes is reported.
//
// Ports:
//   clk, rst_n      clock, synchronous active-low reset
//   en              start pulse, sampled only while rdy=1
//   stop            (only with KEY_SEARCH_STOP_EN) request to end the search
//                   after the in-flight attempt
//   rdy             1 = idle, results stable
//   key_valid       key_out holds a plaintext-valid key
//   key_out[23:0]   found key (0 when key_valid=0)
//   arc4_en         one-cycle start pulse to arc4
//   arc4_rdy        arc4 idle/ready
//   arc4_key[23:0]  key presented to arc4, stable for the whole run
//   pt_addr[7:0]    registered plaintext read address
//   pt_rddata[7:0]  plaintext read data, one cycle after pt_addr
//
// Optional feature macro: KEY_SEARCH_STOP_EN adds the stop input.
module key_search #(
  parameter logic [23:0] KEY_START = 24'h000000,
  parameter logic [23:0] KEY_END   = 24'hFFFFFF,
  parameter logic [23:0] KEY_STEP  = 24'h000001,
  parameter logic [7:0]  CHAR_MIN  = 8'h20,
  parameter logic [7:0]  CHAR_MAX  = 8'h7E
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
`ifdef KEY_SEARCH_STOP_EN
  input  logic        stop,
`endif
  output logic        rdy,
  output logic        key_valid,
  output logic [23:0] key_out,
  output logic        arc4_en,
  input  logic        arc4_rdy,
  output logic [23:0] arc4_key,
  output logic [7:0]  pt_addr,
  input  logic [7:0]  pt_rddata
);

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_WAIT_LO, S_WAIT_HI, S_RD_LEN, S_SCAN, S_NEXT, S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [23:0] arc4_key_q, arc4_key_d;
  logic [23:0] key_out_q, key_out_d;
  logic        key_valid_q, key_valid_d;
  logic [7:0]  pt_addr_q, pt_addr_d;
  logic [7:0]  len_q, len_d;
  logic [7:0]  idx_q, idx_d;     // index of the byte arriving on pt_rddata in SCAN
  logic        stop_req;
  logic        byte_ok;
  logic [7:0]  cur_len;
  logic [24:0] key_next_wide;    // one extra bit so the end-of-range test cannot wrap

`ifdef KEY_SEARCH_STOP_EN
  logic stop_q, stop_d;

  always_comb begin
    stop_d = stop_q;
    if (rdy && en)        stop_d = 1'b0;
    else if (stop && !rdy) stop_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) stop_q <= 1'b0;
    else        stop_q <= stop_d;
  end

  assign stop_req = stop_q | stop;
`else
  assign stop_req = 1'b0;
`endif

  always_comb begin
    byte_ok       = (pt_rddata >= CHAR_MIN) && (pt_rddata <= CHAR_MAX);
    // The first SCAN cycle delivers the length byte itself.
    cur_len       = (idx_q == 8'd0) ? pt_rddata : len_q;
    key_next_wide = {1'b0, arc4_key_q} + {1'b0, KEY_STEP};
  end

  // Next-state and datapath updates.
  always_comb begin
    state_d     = state_q;
    arc4_key_d  = arc4_key_q;
    key_out_d   = key_out_q;
    key_valid_d = key_valid_q;
    pt_addr_d   = pt_addr_q;
    len_d       = len_q;
    idx_d       = idx_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (en) begin
          key_valid_d = 1'b0;
          key_out_d   = '0;
          arc4_key_d  = KEY_START;
          state_d     = S_ISSUE;
        end
      end
      S_ISSUE:   if (arc4_rdy)  state_d = S_WAIT_LO;
      S_WAIT_LO: if (!arc4_rdy) state_d = S_WAIT_HI;
      S_WAIT_HI: begin
        if (arc4_rdy) begin
          pt_addr_d = '0;
          state_d   = S_RD_LEN;
        end
      end
      S_RD_LEN: begin
        // Address 0 is on the bus now; queue address 1 behind it.
        pt_addr_d = 8'd1;
        idx_d     = '0;
        state_d   = S_SCAN;
      end
      S_SCAN: begin
        if (idx_q == 8'd0) begin
          len_d = pt_rddata;
          if (pt_rddata == 8'd0) begin
            pt_addr_d = '0;
            state_d   = S_NEXT;
          end else begin
            idx_d = 8'd1;
            if (pt_addr_q < cur_len) pt_addr_d = pt_addr_q + 8'd1;
          end
        end else if (!byte_ok) begin
          pt_addr_d = '0;
          state_d   = S_NEXT;
        end else if (idx_q == len_q) begin
          pt_addr_d   = '0;
          key_out_d   = arc4_key_q;
          key_valid_d = 1'b1;
          state_d     = S_DONE;
        end else begin
          idx_d = idx_q + 8'd1;
          // Address stalls at L so it never wraps past 255.
          if (pt_addr_q < cur_len) pt_addr_d = pt_addr_q + 8'd1;
        end
      end
      S_NEXT: begin
        if (stop_req || (key_next_wide > {1'b0, KEY_END})) begin
          state_d = S_DONE;
        end else begin
          arc4_key_d = key_next_wide[23:0];
          state_d    = S_ISSUE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    rdy     = (state_q == S_IDLE) || (state_q == S_DONE);
    arc4_en = (state_q == S_ISSUE) && arc4_rdy;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      arc4_key_q  <= KEY_START;
      key_out_q   <= '0;
      key_valid_q <= 1'b0;
      pt_addr_q   <= '0;
      len_q       <= '0;
      idx_q       <= '0;
    end else begin
      state_q     <= state_d;
      arc4_key_q  <= arc4_key_d;
      key_out_q   <= key_out_d;
      key_valid_q <= key_valid_d;
      pt_addr_q   <= pt_addr_d;
      len_q       <= len_d;
      idx_q       <= idx_d;
    end
  end

  assign key_valid = key_valid_q;
  assign key_out   = key_out_q;
  assign arc4_key  = arc4_key_q;
  assign pt_addr   = pt_addr_q;

endmodule

// File: tb/tb_key_search.sv
// Testbench for key_search: three instances (default range, short range ending
// at 4, odd keys near the top of the key space) each beside a small arc4 model
// whose plaintext for a key is described by a per-key record.
module tb_key_search;

  localparam int N = 3;
  localparam logic [23:0] P_START [N] = '{24'h000000, 24'h000000, 24'hFFFFF1};
  localparam logic [23:0] P_END   [N] = '{24'hFFFFFF, 24'h000004, 24'hFFFFFF};
  localparam logic [23:0] P_STEP  [N] = '{24'h000001, 24'h000001, 24'h000002};
  localparam int LOGSZ = 512;

  // Plaintext recipe: byte0=len, byte bad_pos=bad_val, other bytes 1..len=fill,
  // bytes past len read as 8'h00. hello=1 gives "\x05Hello".
  typedef struct packed {
    logic       hello;
    logic [7:0] len;
    logic [7:0] bad_pos;
    logic [7:0] bad_val;
    logic [7:0] fill;
  } desc_t;

  typedef struct {
    desc_t       d;
    bit          ev;
    logic [23:0] ek;
    int          ea;
  } vec_t;

  localparam desc_t D_VALID = '{hello: 1'b0, len: 8'd1, bad_pos: 8'd0, bad_val: 8'h00, fill: 8'h41};
  localparam desc_t D_EMPTY = '{hello: 1'b0, len: 8'd0, bad_pos: 8'd0, bad_val: 8'h00, fill: 8'h41};
  localparam desc_t D_BAD2  = '{hello: 1'b0, len: 8'd3, bad_pos: 8'd2, bad_val: 8'h7F, fill: 8'h41};
  localparam desc_t D_HELLO = '{hello: 1'b1, len: 8'd5, bad_pos: 8'd0, bad_val: 8'h00, fill: 8'h00};

  logic clk = 1'b0;
  logic rst_n;
  logic        en_v        [N];
  logic        rdy_v       [N];
  logic        key_valid_v [N];
  logic [23:0] key_out_v   [N];
  logic        arc4_en_v   [N];
  logic        arc4_rdy_v  [N];
  logic [23:0] arc4_key_v  [N];
  logic [7:0]  pt_addr_v   [N];
  logic [7:0]  pt_rddata_v [N];
`ifdef KEY_SEARCH_STOP_EN
  logic        stop_v      [N];
`endif

  desc_t desc [N][16];
  desc_t dflt [N];

  int unsigned cnt     [N];
  logic [23:0] cur_key [N];
  int          n_en    [N] = '{0, 0, 0};
  int          viol    [N] = '{0, 0, 0};
  logic [23:0] keys_log [N][LOGSZ];
  logic [7:0]  maxa     [N][LOGSZ];

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < N; gi++) begin : g_inst
    key_search #(
      .KEY_START(P_START[gi]),
      .KEY_END  (P_END[gi]),
      .KEY_STEP (P_STEP[gi]),
      .CHAR_MIN (8'h20),
      .CHAR_MAX (8'h7E)
    ) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (en_v[gi]),
`ifdef KEY_SEARCH_STOP_EN
      .stop     (stop_v[gi]),
`endif
      .rdy      (rdy_v[gi]),
      .key_valid(key_valid_v[gi]),
      .key_out  (key_out_v[gi]),
      .arc4_en  (arc4_en_v[gi]),
      .arc4_rdy (arc4_rdy_v[gi]),
      .arc4_key (arc4_key_v[gi]),
      .pt_addr  (pt_addr_v[gi]),
      .pt_rddata(pt_rddata_v[gi])
    );
  end

  function automatic logic [7:0] pt_byte(input desc_t d, input logic [7:0] a);
    logic [39:0] hs;
    hs = "Hello";
    if (d.hello) begin
      if (a == 8'd0) return 8'd5;
      if (a <= 8'd5) return hs[8*(5-int'(a)) +: 8];
      return 8'h00;
    end
    if (a == 8'd0)     return d.len;
    if (a == d.bad_pos) return d.bad_val;
    if (a <= d.len)    return d.fill;
    return 8'h00;
  endfunction

  function automatic desc_t lookup(input int i, input logic [23:0] k);
    if (k < 24'd16) return desc[i][k[3:0]];
    return dflt[i];
  endfunction

  function automatic bit pt_ok(input desc_t d);
    int l;
    logic [7:0] b;
    l = int'(pt_byte(d, 8'd0));
    if (l == 0) return 1'b0;
    for (int j = 1; j <= l; j++) begin
      b = pt_byte(d, 8'(j));
      if (b < 8'h20 || b > 8'h7E) return 1'b0;
    end
    return 1'b1;
  endfunction

  // Reference: walk the key list and return the first key whose plaintext passes.
  task automatic ref_search(input int i, output bit v, output logic [23:0] key, output int att);
    logic [24:0] k;
    k = {1'b0, P_START[i]};
    v = 1'b0; key = '0; att = 0;
    for (int g = 0; g < 4096; g++) begin
      att++;
      if (pt_ok(lookup(i, k[23:0]))) begin
        v = 1'b1; key = k[23:0];
        return;
      end
      if (k + {1'b0, P_STEP[i]} > {1'b0, P_END[i]}) return;
      k = k + {1'b0, P_STEP[i]};
    end
  endtask

  // arc4 + plaintext memory models, plus protocol bookkeeping.
  always_comb begin
    for (int i = 0; i < N; i++) arc4_rdy_v[i] = (cnt[i] == 0);
  end

  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (!rst_n) begin
        cnt[i]     <= 0;
        cur_key[i] <= P_START[i];
      end else if (cnt[i] != 0) begin
        cnt[i] <= cnt[i] - 1;
        if (arc4_en_v[i] || arc4_key_v[i] != cur_key[i] || pt_addr_v[i] != 8'd0)
          viol[i] <= viol[i] + 1;
      end else if (arc4_en_v[i]) begin
        cnt[i]     <= $urandom_range(6, 1);
        cur_key[i] <= arc4_key_v[i];
      end
      if (arc4_en_v[i]) begin
        if (n_en[i] < LOGSZ) begin
          keys_log[i][n_en[i]] <= arc4_key_v[i];
          maxa[i][n_en[i]]     <= 8'd0;
        end
        n_en[i] <= n_en[i] + 1;
      end else if (n_en[i] > 0 && n_en[i] <= LOGSZ) begin
        if (pt_addr_v[i] > maxa[i][n_en[i]-1]) maxa[i][n_en[i]-1] <= pt_addr_v[i];
      end
      pt_rddata_v[i] <= pt_byte(lookup(i, cur_key[i]), pt_addr_v[i]);
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Start instance i (called at a negedge), wait for rdy, compare results.
  task automatic run(input int i, input string name, input bit poke,
                     input bit ev, input logic [23:0] ek, input int ea);
    int base;
    bit done;
    base = n_en[i];
    en_v[i] = 1'b1;
    @(negedge clk);
    en_v[i] = 1'b0;
    check({name, "_busy"}, 64'(rdy_v[i]), 64'(0));
    done = 1'b0;
    for (int c = 0; c < 30000 && !done; c++) begin
      @(negedge clk);
      en_v[i] = 1'b0;
      if (rdy_v[i]) done = 1'b1;
      else if (poke && c == 10) en_v[i] = 1'b1;   // must be ignored while busy
    end
    check({name, "_done"}, 64'(done), 64'(1));
    check({name, "_valid"}, 64'(key_valid_v[i]), 64'(ev));
    check({name, "_key"}, 64'(key_out_v[i]), 64'(ev ? ek : 24'd0));
    check({name, "_attempts"}, 64'(n_en[i] - base), 64'(ea));
  endtask

`ifdef KEY_SEARCH_STOP_EN
  // stop_at=0: stop pulsed while idle; otherwise pulsed once attempt count reaches stop_at.
  task automatic run_stop(input string name, input int stop_at,
                          input bit ev, input logic [23:0] ek, input int ea);
    int base;
    bit done, hit;
    if (stop_at == 0) begin
      stop_v[0] = 1'b1;
      @(negedge clk);
      stop_v[0] = 1'b0;
    end
    base = n_en[0];
    en_v[0] = 1'b1;
    @(negedge clk);
    en_v[0] = 1'b0;
    done = 1'b0;
    hit  = (stop_at == 0);
    for (int c = 0; c < 30000 && !done; c++) begin
      @(negedge clk);
      stop_v[0] = 1'b0;
      if (rdy_v[0]) done = 1'b1;
      else if (!hit && n_en[0] - base == stop_at) begin
        stop_v[0] = 1'b1;
        hit = 1'b1;
      end
    end
    check({name, "_stop_hit"}, 64'(hit), 64'(1));
    check({name, "_done"}, 64'(done), 64'(1));
    check({name, "_valid"}, 64'(key_valid_v[0]), 64'(ev));
    check({name, "_key"}, 64'(key_out_v[0]), 64'(ek));
    check({name, "_attempts"}, 64'(n_en[0] - base), 64'(ea));
  endtask
`endif

  function automatic desc_t rand_desc();
    desc_t d;
    d.hello = 1'b0;
    d.len   = 8'($urandom_range(24, 0));
    d.fill  = 8'($urandom_range(32'h7E, 32'h20));
    if ($urandom_range(1, 0) == 1) begin
      d.bad_pos = 8'($urandom_range(int'(d.len) + 2, 1));
      d.bad_val = ($urandom_range(1, 0) == 1) ? 8'($urandom_range(32'h1F, 0))
                                              : 8'($urandom_range(32'hFF, 32'h7F));
    end else begin
      d.bad_pos = 8'd0;
      d.bad_val = 8'd0;
    end
    return d;
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: time budget exceeded");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl [11];
    bit          rv;
    logic [23:0] rk;
    int          ra, b, nbad;

    // Key-0 plaintext variants; keys >= 1 are valid, so a rejected key 0 yields key 1.
    tbl[0]  = '{'{1'b0, 8'd0,   8'd0,   8'h00, 8'h41}, 1'b1, 24'd1, 2};
    tbl[1]  = '{'{1'b0, 8'd1,   8'd0,   8'h00, 8'h20}, 1'b1, 24'd0, 1};
    tbl[2]  = '{'{1'b0, 8'd1,   8'd0,   8'h00, 8'h7E}, 1'b1, 24'd0, 1};
    tbl[3]  = '{'{1'b0, 8'd1,   8'd1,   8'h1F, 8'h41}, 1'b1, 24'd1, 2};
    tbl[4]  = '{'{1'b0, 8'd1,   8'd1,   8'h7F, 8'h41}, 1'b1, 24'd1, 2};
    tbl[5]  = '{'{1'b0, 8'd3,   8'd3,   8'h00, 8'h41}, 1'b1, 24'd1, 2};
    tbl[6]  = '{'{1'b0, 8'd3,   8'd4,   8'h00, 8'h41}, 1'b1, 24'd0, 1};
    tbl[7]  = '{'{1'b0, 8'd255, 8'd0,   8'h00, 8'h7E}, 1'b1, 24'd0, 1};
    tbl[8]  = '{'{1'b0, 8'd255, 8'd255, 8'hFF, 8'h20}, 1'b1, 24'd1, 2};
    tbl[9]  = '{'{1'b0, 8'd2,   8'd1,   8'h80, 8'h41}, 1'b1, 24'd1, 2};
    tbl[10] = '{'{1'b0, 8'd8,   8'd5,   8'h7F, 8'h20}, 1'b1, 24'd1, 2};

    rst_n = 1'b0;
    for (int i = 0; i < N; i++) begin
      en_v[i] = 1'b0;
`ifdef KEY_SEARCH_STOP_EN
      stop_v[i] = 1'b0;
`endif
      for (int k = 0; k < 16; k++) desc[i][k] = (i == 0) ? D_VALID : ((i == 1) ? D_EMPTY : D_BAD2);
      dflt[i] = (i == 0) ? D_VALID : ((i == 1) ? D_EMPTY : D_BAD2);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < N; i++) begin
      check($sformatf("reset_rdy%0d", i),       64'(rdy_v[i]),       64'(1));
      check($sformatf("reset_valid%0d", i),     64'(key_valid_v[i]), 64'(0));
      check($sformatf("reset_key_out%0d", i),   64'(key_out_v[i]),   64'(0));
      check($sformatf("reset_arc4_en%0d", i),   64'(arc4_en_v[i]),   64'(0));
      check($sformatf("reset_arc4_key%0d", i),  64'(arc4_key_v[i]),  64'(P_START[i]));
      check($sformatf("reset_pt_addr%0d", i),   64'(pt_addr_v[i]),   64'(0));
    end
    repeat (10) @(negedge clk);
    for (int i = 0; i < N; i++)
      check($sformatf("idle_no_arc4_en%0d", i), 64'(n_en[i]), 64'(0));

    for (int r = 0; r < 11; r++) begin
      desc[0][0] = tbl[r].d;
      run(0, $sformatf("vec%0d", r), 1'b0, tbl[r].ev, tbl[r].ek, tbl[r].ea);
    end

    // "\x05Hello" at key 3, keys 0..2 rejected in different ways.
    desc[0][0] = D_EMPTY;
    desc[0][1] = '{hello: 1'b0, len: 8'd5, bad_pos: 8'd1, bad_val: 8'h1F, fill: 8'h41};
    desc[0][2] = '{hello: 1'b0, len: 8'd4, bad_pos: 8'd3, bad_val: 8'h7F, fill: 8'h41};
    desc[0][3] = D_HELLO;
    run(0, "hello", 1'b1, 1'b1, 24'h000003, 4);
    repeat (5) @(negedge clk);
    check("hello_hold_valid", 64'(key_valid_v[0]), 64'(1));
    check("hello_hold_key",   64'(key_out_v[0]),   64'(24'h000003));
    check("hello_hold_rdy",   64'(rdy_v[0]),       64'(1));

    // Early exit: byte 1 of key 0 is 8'h1F; at most the address after it may be
    // on the bus, addresses 3..5 must never appear.
    desc[0][0] = '{hello: 1'b0, len: 8'd5, bad_pos: 8'd1, bad_val: 8'h1F, fill: 8'h41};
    desc[0][1] = D_VALID;
    b = n_en[0];
    run(0, "early", 1'b0, 1'b1, 24'h000001, 2);
    check("early_exit_max_addr_le2", 64'(maxa[0][b] <= 8'd2), 64'(1));

    // Reset in the middle of a search.
    desc[0][0] = D_EMPTY; desc[0][1] = D_EMPTY; desc[0][2] = D_EMPTY; desc[0][3] = D_HELLO;
    en_v[0] = 1'b1;
    @(negedge clk);
    en_v[0] = 1'b0;
    repeat (12) @(negedge clk);
    check("midrst_busy", 64'(rdy_v[0]), 64'(0));
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_rdy",      64'(rdy_v[0]),       64'(1));
    check("midrst_valid",    64'(key_valid_v[0]), 64'(0));
    check("midrst_arc4_key", 64'(arc4_key_v[0]),  64'(0));
    check("midrst_pt_addr",  64'(pt_addr_v[0]),   64'(0));
    rst_n = 1'b1;
    @(negedge clk);

    // Range exhausted: keys 0..4, all with L=0.
    run(1, "range_end4", 1'b0, 1'b0, 24'd0, 5);
    check("range_end4_last_key", 64'(keys_log[1][n_en[1]-1]), 64'(24'h000004));

    // Odd keys up to the top of the key space; the last key must be FFFFFF with no wrap.
    b = n_en[2];
    run(2, "range_top", 1'b0, 1'b0, 24'd0, 8);
    check("range_top_last_key", 64'(keys_log[2][n_en[2]-1]), 64'(24'hFFFFFF));
    nbad = 0;
    for (int j = b; j < n_en[2]; j++)
      if (keys_log[2][j] != 24'hFFFFF1 + 24'(2 * (j - b))) nbad++;
    check("range_top_key_sequence", 64'(nbad), 64'(0));

    for (int t = 0; t < 8; t++) begin
      for (int k = 0; k < 16; k++) desc[0][k] = rand_desc();
      ref_search(0, rv, rk, ra);
      run(0, $sformatf("rand%0d", t), (t % 2 == 1), rv, rk, ra);
    end

`ifdef KEY_SEARCH_STOP_EN
    desc[0][0] = D_EMPTY; desc[0][1] = D_EMPTY; desc[0][2] = D_EMPTY; desc[0][3] = D_HELLO;
    run_stop("stop_key2", 3, 1'b0, 24'd0, 3);
    run_stop("stop_key3_pass", 4, 1'b1, 24'h000003, 4);
    run_stop("stop_idle_ignored", 0, 1'b1, 24'h000003, 4);
`endif

    for (int i = 0; i < N; i++)
      check($sformatf("arc4_protocol%0d", i), 64'(viol[i]), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
